// File: rtl/uop_trace_buffer.sv
// Circular micro-instruction trace recorder with masked-pattern trigger,
// post-trigger capture count and oldest-first readback.
module uop_trace_buffer #(
    parameter  int WIDTH = 112,
    parameter  int DEPTH = 256,
    parameter  int TS_W  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     sample,
    input  logic                 arm,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     trig_mask,
    input  logic [WIDTH-1:0]     trig_value,
    input  logic [AW:0]          post_count,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [TS_W+WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic [1:0]           state,
    output logic                 triggered,
    output logic [AW:0]          count
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_M = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [TS_W+WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [AW:0]           post_rem_q, post_rem_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [WIDTH-1:0]      last_sample_q, last_sample_d;
    logic                  first_flag_q, first_flag_d;
    logic                  triggered_q, triggered_d;
    logic [TS_W+WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic          idle_like, capturing, cap, match, wr_en;
    logic [AW-1:0] phys;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign cap       = sample_valid && ((mode != 2'd1) || first_flag_q || (sample != last_sample_q));
    // The trigger sample bypasses the change-only filter so it is always recorded.
    assign match     = (state_q == ARMED) && sample_valid && (((sample ^ trig_value) & trig_mask) == '0);
    assign wr_en     = capturing && (cap || match);
    assign phys      = wr_ptr_q - count_q[AW-1:0] + rd_addr;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        post_rem_d    = post_rem_q;
        ts_d          = ts_q + TS_W'(1);
        last_sample_d = sample_valid ? sample : last_sample_q;
        first_flag_d  = first_flag_q;
        triggered_d   = triggered_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        if (arm && idle_like) begin
            state_d      = ARMED;
            count_d      = '0;
            wr_ptr_d     = '0;
            triggered_d  = 1'b0;
            first_flag_d = 1'b1;
        end else begin
            if (rd_en && idle_like) begin
                rd_valid_d = 1'b1;
                rd_data_d  = ({1'b0, rd_addr} < count_q) ? mem[phys] : '0;
            end
            if (wr_en) begin
                wr_ptr_d     = wr_ptr_q + AW'(1);
                first_flag_d = 1'b0;
                if (count_q != FULL) count_d = count_q + ONE;
            end
            if (match) begin
                triggered_d = 1'b1;
                post_rem_d  = post_count;
                state_d     = (post_count == '0) ? DONE : POST;
            end else if ((state_q == ARMED) && (mode == 2'd2) && wr_en && (count_q == FULL_M)) begin
                state_d = DONE;
            end else if ((state_q == POST) && cap) begin
                post_rem_d = post_rem_q - ONE;
                if (post_rem_q == ONE) state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            post_rem_q    <= '0;
            ts_q          <= '0;
            last_sample_q <= '0;
            first_flag_q  <= 1'b0;
            triggered_q   <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            post_rem_q    <= post_rem_d;
            ts_q          <= ts_d;
            last_sample_q <= last_sample_d;
            first_flag_q  <= first_flag_d;
            triggered_q   <= triggered_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // Trace RAM has no reset; reads are only allowed while no capture is running.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {ts_q, sample};
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign state     = state_q;
    assign triggered = triggered_q;
    assign count     = count_q;
endmodule
